// File: rtl/plot_arbiter.sv
// plot_arbiter: round-robin two-player pixel arbiter driving a VGA adapter.
// Optional full-screen clear sweep is compiled in by defining PLOT_ARBITER_CLEAR_EN.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   req[1:0]             per-player pixel write request (level)
//   x0/x1, y0/y1, c0/c1  per-player pixel coordinates and colour
//   clear_req            full-screen clear request (ignored unless clear is compiled in)
//   ack[1:0]             one-cycle completion pulse for the served player
//   oor                  one-cycle pulse: granted pixel was off-screen and dropped
//   plot                 VGA write enable
//   x_out/y_out/colour_out  registered pixel to the VGA adapter
//   clear_done           one-cycle pulse after the last cleared pixel
module plot_arbiter #(
  parameter int PLOT_CYCLES = 2,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic [7:0] x0,
  input  logic [7:0] x1,
  input  logic [6:0] y0,
  input  logic [6:0] y1,
  input  logic [2:0] c0,
  input  logic [2:0] c1,
  input  logic       clear_req,
  output logic [1:0] ack,
  output logic       oor,
  output logic       plot,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       clear_done
);
`ifdef PLOT_ARBITER_CLEAR_EN
  typedef enum logic [1:0] {IDLE, PLOT, ACK, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, PLOT, ACK} state_t;
`endif
  state_t state, next;
  logic [3:0] cnt;
  logic last, win, drop, clr, gnt, ok;
  // On a tie the player not served last wins; a lone request wins outright.
  assign gnt = (req == 2'b11) ? ~last : req[1];
  assign ok = gnt ? (x1 <= 8'd159 && y1 <= 7'd119) : (x0 <= 8'd159 && y0 <= 7'd119);
`ifdef PLOT_ARBITER_CLEAR_EN
  logic sweep_end;
  // The output pixel registers double as the sweep position.
  assign sweep_end = x_out == 8'd159 && y_out == 7'd119;
  assign plot = (state == PLOT && !drop) || state == CLEAR;
`else
  logic unused;
  assign unused = clear_req;
  assign clr = 1'b0;
  assign plot = state == PLOT && !drop;
`endif
  // ACK is shared by pixel writes and the clear sweep; clr tells them apart.
  assign ack = (state == ACK && !clr) ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign oor = state == ACK && !clr && drop;
  assign clear_done = state == ACK && clr;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
`ifdef PLOT_ARBITER_CLEAR_EN
      IDLE:  next = clear_req ? CLEAR : (|req ? PLOT : IDLE);
      CLEAR: next = sweep_end ? ACK : CLEAR;
`else
      IDLE:  next = |req ? PLOT : IDLE;
`endif
      PLOT:  next = (cnt == 4'(PLOT_CYCLES - 1)) ? ACK : PLOT;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt <= 4'd0;
      last <= 1'b1;
      win <= 1'b0;
      drop <= 1'b0;
      x_out <= 8'd0;
      y_out <= 7'd0;
      colour_out <= 3'd0;
`ifdef PLOT_ARBITER_CLEAR_EN
      clr <= 1'b0;
`endif
    end else begin
      cnt <= (state == PLOT) ? cnt + 4'd1 : 4'd0;
`ifdef PLOT_ARBITER_CLEAR_EN
      if (state == IDLE) clr <= clear_req;
      if (state == IDLE && clear_req) begin
        x_out <= 8'd0;
        y_out <= 7'd0;
        colour_out <= BG_COLOUR;
      end else if (state == CLEAR && !sweep_end) begin
        x_out <= (x_out == 8'd159) ? 8'd0 : x_out + 8'd1;
        y_out <= (x_out == 8'd159) ? y_out + 7'd1 : y_out;
      end else
`endif
      if (state == IDLE && |req) begin
        win <= gnt;
        last <= gnt;
        drop <= !ok;
        // Off-screen pixels leave the output registers untouched so they only move with plot.
        if (ok) begin
          x_out <= gnt ? x1 : x0;
          y_out <= gnt ? y1 : y0;
          colour_out <= gnt ? c1 : c0;
        end
      end
    end
endmodule
